// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_pkg                                                            |
// | Shared constants and elaboration helpers for the riscv core.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package riscv_pkg;

    localparam int unsigned c_XLEN     = 32;
    localparam int unsigned c_ILEN     = 32;
    localparam logic [31:0] c_INST_NOP = 32'h0000_0013;

    // Ceiling log2 for parameter sizing; returns 0 for values 0 and 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_fetch_unit_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_queue                                                          |
// | Circular {pc,data} buffer: alloc at tail, fill in order, pop at head.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = c_XLEN,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_alloc_en,
    input  logic [XLEN-1:0]   i_alloc_pc,
    input  logic              i_fill_en,
    input  logic [c_ILEN-1:0] i_fill_data,
    input  logic              i_pop_en,
    output logic [XLEN-1:0]   o_head_pc,
    output logic [c_ILEN-1:0] o_head_data,
    output logic [AW:0]       o_count,
    output logic [AW:0]       o_pending,
    output logic              o_valid
);

    logic [AW:0]         tail_q, tail_d;
    logic [AW:0]         fill_q, fill_d;
    logic [AW:0]         head_q, head_d;
    logic [XLEN-1:0]     pc_q   [DEPTH];
    logic [XLEN-1:0]     pc_d   [DEPTH];
    logic [c_ILEN-1:0]   data_q [DEPTH];
    logic [c_ILEN-1:0]   data_d [DEPTH];

    always_comb begin
        tail_d = tail_q;
        fill_d = fill_q;
        head_d = head_q;
        pc_d   = pc_q;
        data_d = data_q;
        if (i_flush) begin
            tail_d = '0;
            fill_d = '0;
            head_d = '0;
        end else begin
            if (i_alloc_en) begin
                pc_d[tail_q[AW-1:0]] = i_alloc_pc;
                tail_d               = tail_q + 1'b1;
            end
            if (i_fill_en) begin
                data_d[fill_q[AW-1:0]] = i_fill_data;
                fill_d                 = fill_q + 1'b1;
            end
            if (i_pop_en) begin
                head_d = head_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tail_q <= '0;
            fill_q <= '0;
            head_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            tail_q <= tail_d;
            fill_q <= fill_d;
            head_q <= head_d;
            pc_q   <= pc_d;
            data_q <= data_d;
        end
    end

    // Extra pointer MSB distinguishes full from empty in the differences.
    assign o_head_pc   = pc_q[head_q[AW-1:0]];
    assign o_head_data = data_q[head_q[AW-1:0]];
    assign o_count     = tail_q - head_q;
    assign o_pending   = tail_q - fill_q;
    assign o_valid     = (head_q != fill_q);

endmodule
`default_nettype wire

// File: rtl/riscv_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_fetch_unit                                                     |
// | Instruction fetch front end: PC sequencing, imem requests, redirect. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module riscv_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned       XLEN     = c_XLEN,
    parameter logic [XLEN-1:0]   RESET_PC = '0,
    parameter int unsigned       FQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [c_ILEN-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [c_ILEN-1:0] inst_data,
    output logic [XLEN-1:0]   inst_pc,
    output logic              err_rsp
);

    localparam int unsigned   c_AW    = clog2(FQ_DEPTH);
    localparam logic [c_AW:0] c_DEPTH = (c_AW + 1)'(FQ_DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [c_AW:0]   drop_cnt_q, drop_cnt_d;
    logic            err_rsp_q,  err_rsp_d;

    logic [c_AW:0]   w_count;
    logic [c_AW:0]   w_pending;
    logic [c_AW:0]   w_squash;
    logic            w_q_valid;
    logic            w_req_fire;
    logic            w_fill;
    logic            w_pop;
    logic            w_unused_pc_lsbs;

    assign w_unused_pc_lsbs = ^redirect_pc[1:0];

    assign imem_req_valid = !rst && fetch_en && !redirect_valid && (w_count != c_DEPTH);
    assign imem_req_addr  = fetch_pc_q;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign inst_valid     = w_q_valid && !redirect_valid;
    assign w_pop          = inst_valid && inst_ready;
    assign err_rsp        = err_rsp_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        err_rsp_d  = err_rsp_q;
        w_fill     = 1'b0;
        // Responses still owed for squashed fetches, queued or in flight.
        w_squash   = drop_cnt_q + w_pending;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            if (imem_rsp_valid) begin
                if (w_squash == '0) begin
                    err_rsp_d = 1'b1;
                end else begin
                    w_squash = w_squash - 1'b1;
                end
            end
            drop_cnt_d = w_squash;
        end else begin
            if (w_req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (imem_rsp_valid) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - 1'b1;
                end else if (w_pending != '0) begin
                    w_fill = 1'b1;
                end else begin
                    err_rsp_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
            err_rsp_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
            err_rsp_q  <= err_rsp_d;
        end
    end

    fetch_queue #(
        .XLEN  (XLEN),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (redirect_valid),
        .i_alloc_en  (w_req_fire),
        .i_alloc_pc  (fetch_pc_q),
        .i_fill_en   (w_fill),
        .i_fill_data (imem_rsp_data),
        .i_pop_en    (w_pop),
        .o_head_pc   (inst_pc),
        .o_head_data (inst_data),
        .o_count     (w_count),
        .o_pending   (w_pending),
        .o_valid     (w_q_valid)
    );

endmodule
`default_nettype wire
